// File: rtl/atm_session_ctrl_if.sv
// Front-end <-> session controller bus: card/keypad requests in, responses,
// balance and mini-statement stream out.
interface atm_session_ctrl_if #(
  parameter int PIN_W = 16,
  parameter int BAL_W = 16
) ();
  logic             card_in;
  logic             pin_valid;
  logic [PIN_W-1:0] pin;
  logic             op_valid;
  logic [1:0]       op;
  logic [BAL_W-1:0] amount;
  logic             admin_unlock;
  logic             op_ready;
  logic             resp_valid;
  logic [2:0]       resp_status;
  logic [BAL_W-1:0] balance;
  logic             hist_valid;
  logic [BAL_W:0]   hist_data;
  logic             hist_last;
  logic             session_active;
  logic             locked;
  logic             eject;

  modport master (
    output card_in, pin_valid, pin, op_valid, op, amount, admin_unlock,
    input  op_ready, resp_valid, resp_status, balance, hist_valid, hist_data,
           hist_last, session_active, locked, eject
  );

  modport slave (
    input  card_in, pin_valid, pin, op_valid, op, amount, admin_unlock,
    output op_ready, resp_valid, resp_status, balance, hist_valid, hist_data,
           hist_last, session_active, locked, eject
  );
endinterface

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card/PIN authentication with lockout, balance
// operations on a single register, timeout abort and a circular
// mini-statement history streamed out on request.
module atm_session_ctrl #(
  parameter int PIN_W        = 16,
  parameter int PIN_VALUE    = 'h1234,
  parameter int BAL_W        = 16,
  parameter int INIT_BALANCE = 1000,
  parameter int MAX_TRIES    = 3,
  parameter int TIMEOUT      = 255,
  parameter int HIST_DEPTH   = 4
) (
  input logic clk,
  input logic rst,
  atm_session_ctrl_if.slave bus
);

  localparam int AW  = $clog2(HIST_DEPTH);
  localparam int CW  = AW + 1;
  localparam int TRW = $clog2(MAX_TRIES + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] ST_OK           = 3'd0;
  localparam logic [2:0] ST_BAD_PIN      = 3'd1;
  localparam logic [2:0] ST_INSUFFICIENT = 3'd2;
  localparam logic [2:0] ST_OVERFLOW     = 3'd3;
  localparam logic [2:0] ST_LOCKED       = 3'd4;
  localparam logic [2:0] ST_TIMEOUT      = 3'd5;

  localparam logic [1:0] OP_BALANCE   = 2'b00;
  localparam logic [1:0] OP_WITHDRAW  = 2'b01;
  localparam logic [1:0] OP_DEPOSIT   = 2'b10;
  localparam logic [1:0] OP_STATEMENT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_AUTH, S_READY, S_STMT, S_LOCKED
  } state_t;

  state_t state, state_nxt;

  logic [TRW-1:0]   tries, tries_nxt;
  logic [TCW-1:0]   tcnt, tcnt_nxt;
  logic [BAL_W-1:0] balance, bal_nxt;
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt, oldest;
  logic [CW-1:0]    count, left, left_nxt;
  logic             resp_valid, resp_valid_nxt;
  logic [2:0]       resp_status, resp_status_nxt;
  logic             hist_valid, hist_valid_nxt;
  logic [BAL_W:0]   hist_data, hist_data_nxt;
  logic             hist_last, hist_last_nxt;
  logic             eject, eject_nxt;
  logic             push;
  logic [BAL_W:0]   push_data;
  logic [BAL_W:0]   sum;
  logic [BAL_W:0]   hist_mem [HIST_DEPTH];

  // Unsigned add with the carry kept as the MSB so overflow is visible.
  function automatic logic [BAL_W:0] add_carry(input logic [BAL_W-1:0] a,
                                               input logic [BAL_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Oldest surviving entry sits count slots behind the write pointer.
  assign oldest = wr_ptr - count[AW-1:0];

  // Next-state, response and datapath decisions for the session FSM.
  always_comb begin
    state_nxt       = state;
    tries_nxt       = tries;
    tcnt_nxt        = tcnt;
    bal_nxt         = balance;
    resp_valid_nxt  = 1'b0;
    resp_status_nxt = resp_status;
    hist_valid_nxt  = 1'b0;
    hist_data_nxt   = hist_data;
    hist_last_nxt   = 1'b0;
    eject_nxt       = 1'b0;
    rd_ptr_nxt      = rd_ptr;
    left_nxt        = left;
    push            = 1'b0;
    push_data       = '0;
    sum             = add_carry(balance, bus.amount);
    case (state)
      S_IDLE: begin
        if (bus.card_in) begin
          state_nxt = S_AUTH;
          tcnt_nxt  = '0;
        end
      end
      S_AUTH: begin
        if (!bus.card_in) begin
          state_nxt = S_IDLE;
          tcnt_nxt  = '0;
        end else if (bus.pin_valid) begin
          tcnt_nxt       = '0;
          resp_valid_nxt = 1'b1;
          if (bus.pin == PIN_W'(PIN_VALUE)) begin
            tries_nxt       = '0;
            resp_status_nxt = ST_OK;
            state_nxt       = S_READY;
          end else begin
            tries_nxt = tries + TRW'(1);
            if (tries + TRW'(1) == TRW'(MAX_TRIES)) begin
              resp_status_nxt = ST_LOCKED;
              state_nxt       = S_LOCKED;
            end else begin
              resp_status_nxt = ST_BAD_PIN;
            end
          end
        end else if (tcnt == TCW'(TIMEOUT)) begin
          resp_valid_nxt  = 1'b1;
          resp_status_nxt = ST_TIMEOUT;
          eject_nxt       = 1'b1;
          state_nxt       = S_IDLE;
          tcnt_nxt        = '0;
        end else begin
          tcnt_nxt = tcnt + TCW'(1);
        end
      end
      S_READY: begin
        if (!bus.card_in) begin
          state_nxt = S_IDLE;
          tcnt_nxt  = '0;
        end else if (bus.op_valid) begin
          tcnt_nxt        = '0;
          resp_valid_nxt  = 1'b1;
          resp_status_nxt = ST_OK;
          case (bus.op)
            OP_WITHDRAW: begin
              if (bus.amount > balance) begin
                resp_status_nxt = ST_INSUFFICIENT;
              end else begin
                bal_nxt   = balance - bus.amount;
                push      = 1'b1;
                push_data = {1'b0, bus.amount};
              end
            end
            OP_DEPOSIT: begin
              if (sum[BAL_W]) begin
                resp_status_nxt = ST_OVERFLOW;
              end else begin
                bal_nxt   = sum[BAL_W-1:0];
                push      = 1'b1;
                push_data = {1'b1, bus.amount};
              end
            end
            OP_STATEMENT: begin
              // An empty history answers at once and never leaves READY.
              if (count != '0) begin
                resp_valid_nxt = 1'b0;
                state_nxt      = S_STMT;
                hist_valid_nxt = 1'b1;
                hist_data_nxt  = hist_mem[oldest];
                hist_last_nxt  = (count == CW'(1));
                rd_ptr_nxt     = oldest + AW'(1);
                left_nxt       = count - CW'(1);
              end
            end
            default: ;
          endcase
        end else if (tcnt == TCW'(TIMEOUT)) begin
          resp_valid_nxt  = 1'b1;
          resp_status_nxt = ST_TIMEOUT;
          eject_nxt       = 1'b1;
          state_nxt       = S_IDLE;
          tcnt_nxt        = '0;
        end else begin
          tcnt_nxt = tcnt + TCW'(1);
        end
      end
      S_STMT: begin
        if (!bus.card_in) begin
          state_nxt = S_IDLE;
          tcnt_nxt  = '0;
        end else if (left != '0) begin
          hist_valid_nxt = 1'b1;
          hist_data_nxt  = hist_mem[rd_ptr];
          hist_last_nxt  = (left == CW'(1));
          rd_ptr_nxt     = rd_ptr + AW'(1);
          left_nxt       = left - CW'(1);
        end else begin
          resp_valid_nxt  = 1'b1;
          resp_status_nxt = ST_OK;
          state_nxt       = S_READY;
          tcnt_nxt        = '0;
        end
      end
      S_LOCKED: begin
        if (bus.admin_unlock) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (bus.admin_unlock) tries_nxt = '0;
  end

  // State, counters, balance and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tries       <= '0;
      tcnt        <= '0;
      balance     <= BAL_W'(INIT_BALANCE);
      wr_ptr      <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      left        <= '0;
      resp_valid  <= 1'b0;
      resp_status <= ST_OK;
      hist_valid  <= 1'b0;
      hist_last   <= 1'b0;
      eject       <= 1'b0;
    end else begin
      state       <= state_nxt;
      tries       <= tries_nxt;
      tcnt        <= tcnt_nxt;
      balance     <= bal_nxt;
      rd_ptr      <= rd_ptr_nxt;
      left        <= left_nxt;
      resp_valid  <= resp_valid_nxt;
      resp_status <= resp_status_nxt;
      hist_valid  <= hist_valid_nxt;
      hist_last   <= hist_last_nxt;
      eject       <= eject_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (count != CW'(HIST_DEPTH)) count <= count + CW'(1);
      end
    end
  end

  // Statement payload and history storage carry no reset; count gates them.
  always_ff @(posedge clk) begin
    hist_data <= hist_data_nxt;
    if (push) hist_mem[wr_ptr] <= push_data;
  end

  assign bus.op_ready       = (state == S_READY);
  assign bus.session_active = (state == S_AUTH) || (state == S_READY) || (state == S_STMT);
  assign bus.locked         = (state == S_LOCKED);
  assign bus.resp_valid     = resp_valid;
  assign bus.resp_status    = resp_status;
  assign bus.balance        = balance;
  assign bus.hist_valid     = hist_valid;
  assign bus.hist_data      = hist_data;
  assign bus.hist_last      = hist_last;
  assign bus.eject          = eject;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl: authentication, lockout, balance
// operations, statement streaming, timeout, card removal and reset.
module tb_atm_session_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   passed;
  int   fails;
  int   early;

  atm_session_ctrl_if #(.PIN_W(16), .BAL_W(16)) bus ();

  atm_session_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [15:0] amt);
    bus.op       = op;
    bus.amount   = amt;
    bus.op_valid = 1'b1;
    tick();
    bus.op_valid = 1'b0;
  endtask

  task automatic do_pin(input logic [15:0] p);
    bus.pin       = p;
    bus.pin_valid = 1'b1;
    tick();
    bus.pin_valid = 1'b0;
  endtask

  initial begin
    total = 0; passed = 0; fails = 0; early = 0;
    rst = 1'b1;
    bus.card_in = 1'b0; bus.pin_valid = 1'b0; bus.pin = '0;
    bus.op_valid = 1'b0; bus.op = '0; bus.amount = '0; bus.admin_unlock = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_status", bus.resp_status, 0);
    check("rst_balance", bus.balance, 1000);
    check("rst_op_ready", bus.op_ready, 0);
    check("rst_locked", bus.locked, 0);
    check("rst_hist_valid", bus.hist_valid, 0);
    check("rst_eject", bus.eject, 0);
    check("rst_active", bus.session_active, 0);

    // card in, correct PIN
    bus.card_in = 1'b1;
    tick();
    check("auth_active", bus.session_active, 1);
    check("auth_op_ready", bus.op_ready, 0);
    do_pin(16'h1234);
    check("pin_ok_valid", bus.resp_valid, 1);
    check("pin_ok_status", bus.resp_status, 0);
    check("ready_op_ready", bus.op_ready, 1);

    // withdraw 300, then insufficient 800
    do_op(2'b01, 16'd300);
    check("wd300_valid", bus.resp_valid, 1);
    check("wd300_status", bus.resp_status, 0);
    check("wd300_balance", bus.balance, 700);
    do_op(2'b01, 16'd800);
    check("wd800_status", bus.resp_status, 2);
    check("wd800_balance", bus.balance, 700);
    tick();
    check("resp_pulse_drop", bus.resp_valid, 0);

    // deposit overflow, exact-fit deposit, withdraw whole balance
    do_op(2'b10, 16'd65000);
    check("dep_ovf_status", bus.resp_status, 3);
    check("dep_ovf_balance", bus.balance, 700);
    do_op(2'b10, 16'd64835);
    check("dep_max_status", bus.resp_status, 0);
    check("dep_max_balance", bus.balance, 65535);
    do_op(2'b01, 16'd65535);
    check("wd_all_status", bus.resp_status, 0);
    check("wd_all_balance", bus.balance, 0);
    do_op(2'b10, 16'd0);
    check("dep0_status", bus.resp_status, 0);
    check("dep0_balance", bus.balance, 0);
    do_op(2'b10, 16'd1000);
    check("dep1000_balance", bus.balance, 1000);

    // statement after 5 pushes: 4 oldest-surviving beats
    do_op(2'b11, 16'd0);
    check("stmt_b0_valid", bus.hist_valid, 1);
    check("stmt_b0_data", bus.hist_data, 17'h10000 + 17'd64835);
    check("stmt_b0_last", bus.hist_last, 0);
    check("stmt_op_ready", bus.op_ready, 0);
    check("stmt_no_resp", bus.resp_valid, 0);
    tick();
    check("stmt_b1_data", bus.hist_data, 65535);
    check("stmt_b1_last", bus.hist_last, 0);
    tick();
    check("stmt_b2_data", bus.hist_data, 17'h10000);
    check("stmt_b2_last", bus.hist_last, 0);
    tick();
    check("stmt_b3_data", bus.hist_data, 17'h10000 + 17'd1000);
    check("stmt_b3_last", bus.hist_last, 1);
    tick();
    check("stmt_end_hvalid", bus.hist_valid, 0);
    check("stmt_end_resp", bus.resp_valid, 1);
    check("stmt_end_status", bus.resp_status, 0);
    check("stmt_end_ready", bus.op_ready, 1);

    // back-to-back balance queries
    bus.op = 2'b00; bus.op_valid = 1'b1;
    tick();
    check("b2b_first", bus.resp_valid, 1);
    tick();
    check("b2b_second", bus.resp_valid, 1);
    bus.op_valid = 1'b0;

    // card removal beats a same-cycle op
    bus.op = 2'b01; bus.amount = 16'd100; bus.op_valid = 1'b1; bus.card_in = 1'b0;
    tick();
    bus.op_valid = 1'b0;
    check("drop_no_resp", bus.resp_valid, 0);
    check("drop_balance", bus.balance, 1000);
    check("drop_inactive", bus.session_active, 0);

    // wrong PINs with tries carried across a card re-insertion
    bus.card_in = 1'b1;
    tick();
    do_pin(16'h1111);
    check("bad1_status", bus.resp_status, 1);
    do_pin(16'h1111);
    check("bad2_status", bus.resp_status, 1);
    bus.card_in = 1'b0;
    tick();
    bus.card_in = 1'b1;
    tick();
    do_pin(16'h2222);
    check("lock_valid", bus.resp_valid, 1);
    check("lock_status", bus.resp_status, 4);
    check("lock_flag", bus.locked, 1);
    do_pin(16'h1234);
    check("locked_ignore_pin", bus.resp_valid, 0);
    check("locked_still", bus.locked, 1);
    bus.admin_unlock = 1'b1;
    tick();
    bus.admin_unlock = 1'b0;
    check("unlock_flag", bus.locked, 0);
    tick();
    do_pin(16'h1234);
    check("unlock_pin_status", bus.resp_status, 0);
    check("unlock_ready", bus.op_ready, 1);

    // idle timeout in READY
    for (int i = 0; i < 255; i++) begin
      tick();
      if (bus.resp_valid) early++;
    end
    check("timeout_early", early, 0);
    tick();
    check("timeout_valid", bus.resp_valid, 1);
    check("timeout_status", bus.resp_status, 5);
    check("timeout_eject", bus.eject, 1);
    check("timeout_inactive", bus.session_active, 0);
    tick();
    check("eject_pulse_drop", bus.eject, 0);

    // reset in the middle of a statement stream (now in AUTH)
    do_pin(16'h1234);
    do_op(2'b11, 16'd0);
    check("pre_rst_hvalid", bus.hist_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_hvalid", bus.hist_valid, 0);
    check("mid_rst_balance", bus.balance, 1000);
    check("mid_rst_inactive", bus.session_active, 0);

    // empty history statement, then overflow from 1000
    tick();
    do_pin(16'h1234);
    do_op(2'b11, 16'd0);
    check("empty_stmt_hvalid", bus.hist_valid, 0);
    check("empty_stmt_resp", bus.resp_valid, 1);
    check("empty_stmt_status", bus.resp_status, 0);
    check("empty_stmt_ready", bus.op_ready, 1);
    do_op(2'b10, 16'd65000);
    check("ovf1000_status", bus.resp_status, 3);
    check("ovf1000_balance", bus.balance, 1000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
